// File: rtl/bus_cycle_ctrl_if.sv
// CPU/decoder side of the 68010 bus-cycle controller: address strobe, decoder
// result, sampled wired DTACK and controller status.
interface bus_cycle_ctrl_if;
    logic       i_AS_n;
    logic       i_CPUSP;
    logic       i_SEL_VALID;
    logic [1:0] i_SEL;
    logic       i_DTACK_n;
    logic       o_BUSY;
    logic       o_TIMEOUT;

    modport slave (
        input  i_AS_n,
        input  i_CPUSP,
        input  i_SEL_VALID,
        input  i_SEL,
        input  i_DTACK_n,
        output o_BUSY,
        output o_TIMEOUT
    );

    modport master (
        output i_AS_n,
        output i_CPUSP,
        output i_SEL_VALID,
        output i_SEL,
        output i_DTACK_n,
        input  o_BUSY,
        input  o_TIMEOUT
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// Per-cycle 68010 bus controller: internal DTACK with per-region wait states,
// and a per-cycle BERR timeout that releases when AS rises.
module bus_cycle_ctrl #(
    parameter int unsigned WS0     = 0,
    parameter int unsigned WS1     = 1,
    parameter int unsigned WS2     = 2,
    parameter int unsigned WS3     = 4,
    parameter int unsigned TIMEOUT = 128,
    parameter int unsigned CW      = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    bus_cycle_ctrl_if.slave       bus,
    // Open-drain lines stay plain ports so they can join the wired-OR bus nets.
    output wire                   o_DTACK_n,
    output wire                   o_BERR_n
);

    localparam int unsigned WW = CW;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_WAIT,
        S_EXT,
        S_ACK,
        S_ERR,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [WW-1:0]   r_wait;
    logic [CW-1:0]   r_cnt;
    logic            r_dtack;
    logic            r_berr;
    logic            r_busy;
    logic            r_tout;

    logic [WW-1:0]   w_ws;
    logic            w_internal;
    logic            w_expired;
    logic [CW-1:0]   w_cnt_inc;

    // Wait-state lookup for the region currently presented by the decoder.
    always_comb begin
        w_ws = WW'(WS0);
        case (bus.i_SEL)
            2'd0:    w_ws = WW'(WS0);
            2'd1:    w_ws = WW'(WS1);
            2'd2:    w_ws = WW'(WS2);
            default: w_ws = WW'(WS3);
        endcase
    end

    assign w_internal = bus.i_SEL_VALID && !bus.i_CPUSP;
    assign w_expired  = (r_cnt == CW'(TIMEOUT));
    assign w_cnt_inc  = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state <= S_DRAIN;
            r_wait  <= '0;
            r_cnt   <= '0;
            r_dtack <= 1'b0;
            r_berr  <= 1'b0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_tout <= 1'b0;
            case (r_state)
                S_DRAIN: begin
                    if (bus.i_AS_n) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!bus.i_AS_n) begin
                        r_cnt  <= CW'(1);
                        r_busy <= 1'b1;
                        if (w_internal && (w_ws == '0)) begin
                            r_state <= S_ACK;
                            r_dtack <= 1'b1;
                        end else if (w_internal) begin
                            r_state <= S_WAIT;
                            r_wait  <= w_ws - WW'(1);
                        end else begin
                            r_state <= S_EXT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.i_AS_n) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wait == '0) begin
                        r_state <= S_ACK;
                        r_dtack <= 1'b1;
                    end else if (w_expired) begin
                        r_state <= S_ERR;
                        r_berr  <= 1'b1;
                        r_tout  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - WW'(1);
                        r_cnt  <= w_cnt_inc;
                    end
                end
                S_EXT: begin
                    // External devices terminate their own cycles; we never drive DTACK here.
                    if (bus.i_AS_n) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!bus.i_DTACK_n) begin
                        r_state <= S_DONE;
                    end else if (w_expired) begin
                        r_state <= S_ERR;
                        r_berr  <= 1'b1;
                        r_tout  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ACK, S_ERR, S_DONE: begin
                    if (bus.i_AS_n) begin
                        r_state <= S_IDLE;
                        r_dtack <= 1'b0;
                        r_berr  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_DRAIN;
                    r_dtack <= 1'b0;
                    r_berr  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_DTACK_n     = r_dtack ? 1'b0 : 1'bz;
    assign o_BERR_n      = r_berr  ? 1'b0 : 1'bz;
    assign bus.o_BUSY    = r_busy;
    assign bus.o_TIMEOUT = r_tout;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl; open-drain outputs are pulled up so a
// released line reads as 1.
module tb_bus_cycle_ctrl;

    logic r_clk;
    logic r_rst;
    wire  w_dtack_n;
    wire  w_berr_n;
    int   r_total;
    int   r_bad;

    bus_cycle_ctrl_if bif ();

    pullup (w_dtack_n);
    pullup (w_berr_n);

    bus_cycle_ctrl #(
        .WS0(0), .WS1(1), .WS2(2), .WS3(4), .TIMEOUT(128), .CW(8)
    ) dut (
        .i_CLK     (r_clk),
        .i_RST     (r_rst),
        .bus       (bif),
        .o_DTACK_n (w_dtack_n),
        .o_BERR_n  (w_berr_n)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle before sampling or driving.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic r_any_ack;
        r_total = 0;
        r_bad   = 0;

        // Reset held with AS low: DRAIN, lines released, idle status.
        r_rst = 1'b1;
        bif.i_AS_n = 1'b0; bif.i_CPUSP = 1'b0; bif.i_SEL_VALID = 1'b0;
        bif.i_SEL = 2'd0;  bif.i_DTACK_n = 1'b1;
        tick(5);
        chk("rst_dtack", 32'(w_dtack_n), 32'd1);
        chk("rst_berr",  32'(w_berr_n),  32'd1);
        chk("rst_busy",  32'(bif.o_BUSY), 32'd0);
        chk("rst_tout",  32'(bif.o_TIMEOUT), 32'd0);
        r_rst = 1'b0;
        tick(3);
        chk("drain_hold_busy", 32'(bif.o_BUSY), 32'd0);
        bif.i_AS_n = 1'b1;
        tick(1);

        // Region 2, two wait states: DTACK from N+2, released at N+6.
        bif.i_SEL_VALID = 1'b1; bif.i_SEL = 2'd2; bif.i_AS_n = 1'b0;
        tick(1);
        chk("ws2_n_busy",  32'(bif.o_BUSY), 32'd1);
        chk("ws2_n_dtack", 32'(w_dtack_n), 32'd1);
        tick(1);
        chk("ws2_n1_dtack", 32'(w_dtack_n), 32'd1);
        tick(1);
        chk("ws2_n2_dtack", 32'(w_dtack_n), 32'd0);
        tick(3);
        chk("ws2_n5_dtack", 32'(w_dtack_n), 32'd0);
        chk("ws2_n5_berr",  32'(w_berr_n), 32'd1);
        bif.i_AS_n = 1'b1;
        tick(1);
        chk("ws2_n6_dtack", 32'(w_dtack_n), 32'd1);
        chk("ws2_n6_busy",  32'(bif.o_BUSY), 32'd0);

        // External cycle terminated by bus DTACK at N+10.
        bif.i_SEL_VALID = 1'b0; bif.i_AS_n = 1'b0;
        r_any_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (w_dtack_n === 1'b0) r_any_ack = 1'b1;
        end
        chk("ext_no_int_ack", 32'(r_any_ack), 32'd0);
        chk("ext_busy", 32'(bif.o_BUSY), 32'd1);
        bif.i_DTACK_n = 1'b0;
        tick(1);
        chk("ext_done_dtack", 32'(w_dtack_n), 32'd1);
        chk("ext_done_berr",  32'(w_berr_n), 32'd1);
        chk("ext_done_busy",  32'(bif.o_BUSY), 32'd1);
        bif.i_AS_n = 1'b1; bif.i_DTACK_n = 1'b1;
        tick(1);
        chk("ext_rel_busy", 32'(bif.o_BUSY), 32'd0);

        // Timeout: BERR from N+128, one-cycle TIMEOUT pulse.
        bif.i_AS_n = 1'b0;
        tick(1);
        tick(127);
        chk("to_n127_berr", 32'(w_berr_n), 32'd1);
        chk("to_n127_tout", 32'(bif.o_TIMEOUT), 32'd0);
        tick(1);
        chk("to_n128_berr", 32'(w_berr_n), 32'd0);
        chk("to_n128_tout", 32'(bif.o_TIMEOUT), 32'd1);
        tick(1);
        chk("to_n129_tout", 32'(bif.o_TIMEOUT), 32'd0);
        chk("to_n129_berr", 32'(w_berr_n), 32'd0);
        tick(20);
        chk("to_hold_berr", 32'(w_berr_n), 32'd0);
        bif.i_AS_n = 1'b1;
        tick(1);
        chk("to_rel_berr", 32'(w_berr_n), 32'd1);
        chk("to_rel_busy", 32'(bif.o_BUSY), 32'd0);

        // Next cycle after a timeout acks normally (region 1, one wait).
        bif.i_SEL_VALID = 1'b1; bif.i_SEL = 2'd1; bif.i_AS_n = 1'b0;
        tick(1);
        chk("post_to_n_dtack", 32'(w_dtack_n), 32'd1);
        tick(1);
        chk("post_to_n1_dtack", 32'(w_dtack_n), 32'd0);
        chk("post_to_berr", 32'(w_berr_n), 32'd1);
        bif.i_AS_n = 1'b1;
        tick(1);

        // Zero-wait region acks on the sampling edge.
        bif.i_SEL = 2'd0; bif.i_AS_n = 1'b0;
        tick(1);
        chk("ws0_n_dtack", 32'(w_dtack_n), 32'd0);
        bif.i_AS_n = 1'b1;
        tick(1);
        chk("ws0_rel_dtack", 32'(w_dtack_n), 32'd1);

        // CPU-space cycle with a valid region goes external.
        bif.i_CPUSP = 1'b1; bif.i_AS_n = 1'b0;
        tick(1);
        chk("cpusp_n_dtack", 32'(w_dtack_n), 32'd1);
        chk("cpusp_n_busy",  32'(bif.o_BUSY), 32'd1);
        tick(3);
        chk("cpusp_n3_dtack", 32'(w_dtack_n), 32'd1);
        bif.i_AS_n = 1'b1; bif.i_CPUSP = 1'b0;
        tick(1);

        // Region latched in IDLE: SEL changes to 0 mid-cycle are ignored.
        bif.i_SEL = 2'd3; bif.i_AS_n = 1'b0;
        tick(1);
        bif.i_SEL = 2'd0;
        tick(3);
        chk("latch_n3_dtack", 32'(w_dtack_n), 32'd1);
        tick(1);
        chk("latch_n4_dtack", 32'(w_dtack_n), 32'd0);
        bif.i_AS_n = 1'b1;
        tick(1);

        // Aborted wait cycle: AS rises before the ack, no error.
        bif.i_SEL = 2'd3; bif.i_AS_n = 1'b0;
        tick(2);
        bif.i_AS_n = 1'b1;
        tick(1);
        chk("abort_busy",  32'(bif.o_BUSY), 32'd0);
        chk("abort_dtack", 32'(w_dtack_n), 32'd1);
        chk("abort_berr",  32'(w_berr_n), 32'd1);

        // Reset mid-WAIT: no ack, DRAIN until AS high.
        bif.i_AS_n = 1'b0;
        tick(1);
        r_rst = 1'b1;
        tick(1);
        r_rst = 1'b0;
        r_any_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (w_dtack_n === 1'b0 || bif.o_BUSY === 1'b1) r_any_ack = 1'b1;
        end
        chk("rstmid_no_ack", 32'(r_any_ack), 32'd0);
        chk("rstmid_berr", 32'(w_berr_n), 32'd1);
        bif.i_AS_n = 1'b1;
        tick(1);
        bif.i_SEL = 2'd0; bif.i_AS_n = 1'b0;
        tick(1);
        chk("rstmid_recover_dtack", 32'(w_dtack_n), 32'd0);
        bif.i_AS_n = 1'b1;
        tick(1);
        chk("rstmid_recover_rel", 32'(w_dtack_n), 32'd1);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
